poly_compress_pack: RTL and testbench
=====================================

Name: poly_compress_pack

Overview:
- Downstream stage of the Kyber coefficient compressor in the ATHOS accelerator.
- Takes a stream of compressed coefficients (d = 4, 5, 10 or 11 bits) and packs them LSB-first into 32-bit words for ciphertext serialization to memory.
- Tracks one polynomial of NCOEFF coefficients per job, flags the final word, pulses done.

Parameters:
- NCOEFF, 256, coefficients per polynomial (job length).
- WORD_W, 32, output word width; fixed at 32 in this revision.
- COEFF_W, 11, input coefficient port width (max d).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  job start; sampled only in IDLE.
- mode_i  in  2  packing width, latched at start: 00 d=4, 01 d=5, 10 d=10, 11 d=11.
- coeff_valid_i  in  1  coefficient valid.
- coeff_ready_o  out  1  coefficient ready.
- coeff_i  in  COEFF_W  compressed coefficient; only bits [d-1:0] used.
- word_valid_o  out  1  packed word valid.
- word_ready_i  in  1  packed word accepted.
- word_o  out  WORD_W  packed word.
- word_last_o  out  1  qualifies the final word of the job.
- busy_o  out  1  high in PACK and DRAIN.
- done_o  out  1  one-cycle pulse when the job completes.
- err_o  out  1  sticky range error (see Optional Feature).

Behaviour:
- Reset values: all outputs 0. Internal state after reset: FSM = IDLE, acc_q = 0, fill_q = 0, cnt_q = 0, mode_q = 00.
- Datapath: 64-bit accumulator acc_q; fill_q (0..63) holds the number of valid bits.
- Push: on a coefficient handshake, coeff_i[d-1:0] is written at acc[fill +: d] and fill increases by d.
- Pop: on a word handshake, acc shifts right by 32 and fill decreases by 32.
- Simultaneous push and pop in one cycle: the shift is applied first, so the coefficient lands at position fill_q-32 and fill_next = fill_q - 32 + d.
- FSM states:
  - IDLE: start_i=1 latches mode_i, clears acc, fill and cnt, then goes to PACK the next cycle. start_i is ignored in every other state.
  - PACK: coeff_ready_o = (fill_q < 32) && (cnt_q < NCOEFF), registered, with no combinational path from word_ready_i. cnt_q increments on each coefficient handshake. Go to DRAIN when cnt reaches NCOEFF.
  - DRAIN: coeff_ready_o = 0. Emit the remaining words. Go to IDLE when fill reaches 0, asserting done_o for exactly that cycle.
- Output word: word_valid_o = (fill_q >= 32) in PACK and DRAIN, or (fill_q > 0) in DRAIN. A partial final word is zero-padded above fill_q. word_o = acc_q[31:0].
- word_last_o = word_valid_o && DRAIN-bound && no bits remain after this pop. For d in {4,5,10,11} with NCOEFF=256, word counts are 32, 40, 80 and 88, with no padding.
- Output stability: word_o, word_valid_o and word_last_o are held stable while word_valid_o=1 and word_ready_i=0.
- Throughput: at most one coefficient and one word per cycle. One bubble on the coefficient side per emitted word is permitted.
- Arithmetic: coefficient bits above d are masked to 0 before insertion, so the accumulator never holds stray bits.
- Reset mid-job: async clear to IDLE. The partially packed word is discarded, no done_o pulse.

Optional Feature:
- Macro: POLY_COMPRESS_PACK_RANGE_CHECK_EN.
- Defined: err_o is set when a coefficient handshake carries a non-zero bit in coeff_i[COEFF_W-1:d]. It is sticky until the next start_i or reset, and the masked value is still packed.
- Undefined: no check logic; err_o is tied to 0.

Decomposition:
- athos_pkg gains:
  - pack_mode_e (PACK_D4, PACK_D5, PACK_D10, PACK_D11);
  - PACK_WORD_W = 32 and PACK_ACC_W = 64;
  - a function pack_width(pack_mode_e) returning d.
- Single module; no sub-module. The insert/shift logic stays inline.

Test Plan:
- d=4, coeff_i = i mod 16 for i = 0..255, word_ready_i=1 -> 32 words, word0 = 0x76543210, word_last_o on word 32 only, done_o pulses once.
- d=5, all coefficients 0x1F -> 40 words, each 0xFFFFFFFF, last on word 40, busy_o falls with done_o.
- d=10, coefficients 1, 2, 3, 4, ... -> word0 = 0x00300801. Bits 31:30 hold 4[1:0]=0, and word1 bits [7:0] = 0x01 from 4>>2.
- Backpressure, d=11: hold word_ready_i=0 for 10 cycles mid-job -> word_o stable, coeff_ready_o=0 once fill_q>=32. After release, 88 words, no loss or duplication against a reference bitstream.
- Reset: assert rst_ni low after 100 coefficients -> all outputs 0 immediately. A new start_i completes a fresh 256-coefficient job correctly.
- With macro, d=4, coeff_i=0x013 -> err_o=1 from the next cycle and the packed nibble = 0x3. Without macro, err_o stays 0.

Source files
------------

// File: rtl/athos_pkg.sv
// Shared ATHOS types: packing modes, word and accumulator widths,
// and the coefficient-width lookup used by the ciphertext packer.
package athos_pkg;

    typedef enum logic [1:0] {
        PACK_D4  = 2'b00,
        PACK_D5  = 2'b01,
        PACK_D10 = 2'b10,
        PACK_D11 = 2'b11
    } pack_mode_e;

    typedef enum logic [1:0] {
        PK_IDLE  = 2'b00,
        PK_PACK  = 2'b01,
        PK_DRAIN = 2'b10
    } pack_state_e;

    localparam int PACK_WORD_W = 32;
    localparam int PACK_ACC_W  = 64;

    function automatic logic [3:0] pack_width(pack_mode_e m);
        logic [3:0] d;
        d = 4'd4;
        unique case (m)
            PACK_D4:  d = 4'd4;
            PACK_D5:  d = 4'd5;
            PACK_D10: d = 4'd10;
            PACK_D11: d = 4'd11;
            default:  d = 4'd4;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/poly_compress_pack.sv
// Packs d-bit compressed Kyber coefficients LSB-first into 32-bit words.
// Ports: clk_i, rst_ni (async low); start_i/mode_i begin a job;
// coeff_valid_i/coeff_ready_o/coeff_i input stream; word_valid_o/
// word_ready_i/word_o/word_last_o output stream; busy_o, done_o, err_o.
// Optional macro POLY_COMPRESS_PACK_RANGE_CHECK_EN enables err_o, a sticky
// flag for coefficients carrying bits above d (otherwise tied to 0).
module poly_compress_pack
    import athos_pkg::*;
#(
    parameter int NCOEFF  = 256,
    parameter int WORD_W  = 32,
    parameter int COEFF_W = 11
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic               coeff_valid_i,
    output logic               coeff_ready_o,
    input  logic [COEFF_W-1:0] coeff_i,
    output logic               word_valid_o,
    input  logic               word_ready_i,
    output logic [WORD_W-1:0]  word_o,
    output logic               word_last_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int CNT_W = $clog2(NCOEFF + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NCOEFF);

    pack_state_e              state_q, state_d;
    pack_mode_e               mode_q, mode_d;
    logic [PACK_ACC_W-1:0]    acc_q, acc_d;
    logic [5:0]               fill_q, fill_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ready_q, ready_d;
    logic                     done_q, done_d;

    logic [5:0]               d;
    logic [5:0]               base;
    logic [COEFF_W-1:0]       mask;
    logic [COEFF_W-1:0]       coeff_m;
    logic [PACK_ACC_W-1:0]    ins;
    logic                     push;
    logic                     pop;
    logic                     wvalid;

`ifdef POLY_COMPRESS_PACK_RANGE_CHECK_EN
    logic err_q, err_d;
`endif

    // A partial last word is only offered once no more coefficients come.
    assign wvalid = ((state_q == PK_PACK) && (fill_q >= 6'd32)) ||
                    ((state_q == PK_DRAIN) && (fill_q != 6'd0));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef POLY_COMPRESS_PACK_RANGE_CHECK_EN
        err_d   = err_q;
`endif
        d       = {2'b00, pack_width(mode_q)};
        mask    = ~({COEFF_W{1'b1}} << d);
        coeff_m = coeff_i & mask;
        push    = ready_q && coeff_valid_i;
        pop     = wvalid && word_ready_i;
        // Shift happens before insertion when both occur together.
        base    = pop ? (fill_q - 6'd32) : fill_q;
        ins     = {{(PACK_ACC_W-COEFF_W){1'b0}}, coeff_m} << base;

        unique case (state_q)
            PK_IDLE: begin
                if (start_i) begin
                    mode_d  = pack_mode_e'(mode_i);
                    acc_d   = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                    state_d = PK_PACK;
`ifdef POLY_COMPRESS_PACK_RANGE_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            PK_PACK, PK_DRAIN: begin
                if (pop) begin
                    acc_d  = acc_q >> PACK_WORD_W;
                    fill_d = base;
                end
                if (push) begin
                    acc_d  = acc_d | ins;
                    fill_d = base + d;
                    cnt_d  = cnt_q + CNT_W'(1);
`ifdef POLY_COMPRESS_PACK_RANGE_CHECK_EN
                    if ((coeff_i & ~mask) != '0) err_d = 1'b1;
`endif
                end
                if ((state_q == PK_PACK) && (cnt_d == CNT_MAX)) begin
                    state_d = PK_DRAIN;
                end
                if ((state_q == PK_DRAIN) && (fill_d == 6'd0)) begin
                    state_d = PK_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = PK_IDLE;
        endcase

        // Registered ready: looks only at next-cycle fill and count.
        ready_d = (state_d == PK_PACK) && (fill_d < 6'd32) &&
                  (cnt_d < CNT_MAX);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= PK_IDLE;
            mode_q  <= PACK_D4;
            acc_q   <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

`ifdef POLY_COMPRESS_PACK_RANGE_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_d;
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign coeff_ready_o = ready_q;
    assign word_valid_o  = wvalid;
    assign word_o        = acc_q[WORD_W-1:0];
    assign word_last_o   = wvalid && (state_q == PK_DRAIN) &&
                           (fill_q <= 6'd32);
    assign busy_o        = (state_q != PK_IDLE);
    assign done_o        = done_q;

endmodule

// File: tb/tb_poly_compress_pack.sv
// Self-checking bench for poly_compress_pack: table-driven jobs,
// backpressure, mid-job reset, range-error and randomized jobs.
module tb_poly_compress_pack;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  mode_i = 2'b00;
    logic        cv = 1'b0;
    logic        cr;
    logic [10:0] coeff_i = '0;
    logic        wv;
    logic        wr = 1'b0;
    logic [31:0] word;
    logic        wl;
    logic        busy;
    logic        done;
    logic        err;

    poly_compress_pack #(.NCOEFF(N), .WORD_W(32), .COEFF_W(11)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .mode_i(mode_i),
        .coeff_valid_i(cv), .coeff_ready_o(cr), .coeff_i(coeff_i),
        .word_valid_o(wv), .word_ready_i(wr), .word_o(word),
        .word_last_o(wl), .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

`ifdef POLY_COMPRESS_PACK_RANGE_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    int          coeffs[N];
    logic [10:0] drv[N];
    logic [31:0] got_q[$];
    bit          last_q[$];
    logic [31:0] exp_q[$];

    typedef struct {
        int          mode;
        int          pat;
        logic [31:0] w0;
        int          nw;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int dw(input int m);
        return (m == 0) ? 4 : (m == 1) ? 5 : (m == 2) ? 10 : 11;
    endfunction

    // Reference: lay all coefficient bits out as one bitstream, then
    // cut it into 32-bit words, zero-padding the tail.
    task automatic build_model(input int m);
        bit bits[$];
        logic [31:0] w;
        int d;
        d = dw(m);
        exp_q.delete();
        for (int i = 0; i < N; i++)
            for (int b = 0; b < d; b++)
                bits.push_back(((coeffs[i] >> b) & 1) != 0);
        while (bits.size() > 0) begin
            w = '0;
            for (int b = 0; b < 32 && bits.size() > 0; b++)
                w[b] = bits.pop_front();
            exp_q.push_back(w);
        end
    endtask

    task automatic fill_pattern(input int m, input int pat);
        int mask;
        mask = (1 << dw(m)) - 1;
        for (int i = 0; i < N; i++) begin
            case (pat)
                0:       coeffs[i] = i % 16;
                1:       coeffs[i] = mask;
                2:       coeffs[i] = (i + 1) & mask;
                default: coeffs[i] = $urandom & mask;
            endcase
            drv[i] = 11'(coeffs[i]);
        end
    endtask

    task automatic run_job(input int m, input int ready_pct,
                           input int valid_pct, input int bp_at,
                           input int abort_at, input bit exp_err,
                           input string tag);
        int ci, cyc, hold;
        bit prev_hold, bp_done, err_pending, in_bp, aborted, finished;
        logic [31:0] pw;
        logic pl;
        ci = 0; cyc = 0; hold = 0;
        prev_hold = 0; bp_done = 0; err_pending = 0;
        aborted = 0; finished = 0; pw = '0; pl = 0;
        got_q.delete();
        last_q.delete();
        @(negedge clk);
        start_i = 1'b1;
        mode_i = 2'(m);
        @(negedge clk);
        start_i = 1'b0;
        check({tag, " busy after start"}, busy, 1);
        check({tag, " ready after start"}, cr, 1);
        check({tag, " err cleared"}, err, 0);
        while (cyc < 5000) begin
            if (err_pending) begin
                check({tag, " err after coeff0"}, err, exp_err);
                err_pending = 0;
            end
            if (done) begin
                check({tag, " busy falls with done"}, busy, 0);
                check({tag, " err sticky"}, err, exp_err);
                finished = 1;
                break;
            end
            if (abort_at >= 0 && ci == abort_at) begin
                cv = 1'b0;
                wr = 1'b0;
                rst_n = 1'b0;
                #1;
                check({tag, " rst outs"},
                      {cr, wv, word, wl, busy, done, err}, '0);
                @(negedge clk);
                rst_n = 1'b1;
                aborted = 1;
                break;
            end
            cv = (ci < N) && ($urandom_range(99) < valid_pct);
            coeff_i = (ci < N) ? drv[ci] : '0;
            if (bp_at >= 0 && ci >= bp_at && !bp_done) begin
                hold = 10;
                bp_done = 1;
            end
            in_bp = (hold > 0);
            if (hold > 0) begin
                wr = 1'b0;
                hold--;
            end else begin
                wr = ($urandom_range(99) < ready_pct);
            end
            #1;
            if (prev_hold) begin
                check({tag, " held valid"}, wv, 1);
                check({tag, " held word"}, word, pw);
                check({tag, " held last"}, wl, pl);
            end
            if (in_bp && wv) check({tag, " ready low in hold"}, cr, 0);
            if (cv && cr) begin
                if (ci == 0) err_pending = 1;
                ci++;
            end
            if (wv && wr) begin
                got_q.push_back(word);
                last_q.push_back(wl);
            end
            prev_hold = wv && !wr;
            pw = word;
            pl = wl;
            @(negedge clk);
            cyc++;
        end
        cv = 1'b0;
        wr = 1'b0;
        if (aborted) return;
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no done expected done", tag);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        @(negedge clk);
        check({tag, " done one cycle"}, done, 0);
        build_model(m);
        check({tag, " word count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            check($sformatf("%s word%0d", tag, k), got_q[k], exp_q[k]);
            check($sformatf("%s last%0d", tag, k), last_q[k],
                  (k == exp_q.size() - 1));
        end
    endtask

    vec_t vt[5];

    initial begin
        vt[0] = '{0, 0, 32'h76543210, 32};
        vt[1] = '{1, 1, 32'hFFFFFFFF, 40};
        vt[2] = '{2, 2, 32'h00300801, 80};
        vt[3] = '{3, 2, 32'h00C01001, 88};
        vt[4] = '{1, 2, 32'hCC520C41, 40};

        #1;
        check("reset outs", {cr, wv, word, wl, busy, done, err}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            fill_pattern(vt[v].mode, vt[v].pat);
            run_job(vt[v].mode, 100, 100, -1, -1, 0,
                    $sformatf("vec%0d", v));
            check($sformatf("vec%0d nwords", v), got_q.size(), vt[v].nw);
            if (got_q.size() > 0)
                check($sformatf("vec%0d word0", v), got_q[0], vt[v].w0);
        end

        fill_pattern(2, 2);
        run_job(2, 100, 100, -1, -1, 0, "d10");
        if (got_q.size() > 1)
            check("d10 word1 low byte", got_q[1][7:0], 8'h01);

        fill_pattern(3, 3);
        run_job(3, 100, 100, 40, -1, 0, "bp");

        fill_pattern(1, 3);
        run_job(1, 100, 100, -1, 100, 0, "abort");
        fill_pattern(1, 3);
        run_job(1, 100, 100, -1, -1, 0, "fresh");

        fill_pattern(0, 0);
        drv[0] = 11'h013;
        coeffs[0] = 3;
        run_job(0, 100, 100, -1, -1, ERR_EN, "rng");
        if (got_q.size() > 0)
            check("rng nibble", got_q[0][3:0], 4'h3);

        for (int r = 0; r < 4; r++) begin
            int m;
            m = $urandom_range(3);
            fill_pattern(m, 3);
            run_job(m, 60, 70, -1, -1, 0, $sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
